tron_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the Tron core. It owns the

---
 rtl/tron_pkg.sv | 31 +++
 rtl/tron_fetch_fifo.sv | 61 ++++++
 rtl/tron_fetch_unit.sv | 100 ++++++++++
 tb/tb_tron_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared Tron fetch definitions: default widths, reset PC, fetch FSM states
// and helpers that slice the four 4-bit fields of a Tron instruction word.
package tron_pkg;

  localparam int TRON_ADDR_W  = 16;
  localparam int TRON_INSTR_W = 16;
  localparam logic [TRON_ADDR_W-1:0] TRON_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  function automatic logic [3:0] op_field3(input logic [15:0] ins);
    return ins[15:12];
  endfunction

  function automatic logic [3:0] op_field2(input logic [15:0] ins);
    return ins[11:8];
  endfunction

  function automatic logic [3:0] op_field1(input logic [15:0] ins);
    return ins[7:4];
  endfunction

  function automatic logic [3:0] op_field0(input logic [15:0] ins);
    return ins[3:0];
  endfunction

endpackage

// File: rtl/tron_fetch_fifo.sv
// Prefetch FIFO of {instr, pc} pairs with flush and occupancy count.
// Head outputs read straight from storage and read as zero while empty.
module tron_fetch_fifo
  import tron_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int INSTR_W = TRON_INSTR_W,
  parameter int ADDR_W  = TRON_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_flush,
  input  logic                    i_push,
  input  logic [INSTR_W-1:0]      i_instr,
  input  logic [ADDR_W-1:0]       i_pc,
  input  logic                    i_pop,
  output logic [INSTR_W-1:0]      o_instr,
  output logic [ADDR_W-1:0]       o_pc,
  output logic                    o_valid,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW:0]        r_count;
  logic               w_push;
  logic               w_pop;

  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && (r_count != '0) && !i_flush;

  always_ff @(posedge clk) begin
    if (!reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  // Storage is data only; validity comes from the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= i_instr;
      r_pc_mem[r_wr_ptr]    <= i_pc;
    end
  end

  assign o_valid = (r_count != '0);
  assign o_instr = o_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign o_pc    = o_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/tron_fetch_unit.sv
// Tron instruction fetch: PC, 1-cycle program-memory reads, prefetch FIFO,
// redirect flush and halt handling in front of the core's valid/ready port.
module tron_fetch_unit
  import tron_pkg::*;
#(
  parameter int                ADDR_W   = TRON_ADDR_W,
  parameter int                INSTR_W  = TRON_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = TRON_RESET_PC,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic [ADDR_W-1:0]  fetch_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic [CW-1:0]     w_count;
  logic [CW:0]       w_used;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;

  assign w_pop  = instr_valid && instr_ready;
  assign w_push = r_inflight && !redirect_valid;
  // Credit counts the head leaving this cycle so a full stream keeps 1 instr/cycle.
  assign w_used = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_RUN, S_FLUSH: begin
        w_issue = reset && !halt && !redirect_valid && (w_used < (CW+1)'(DEPTH));
        if (redirect_valid) w_state_nxt = S_FLUSH;
        else if (halt)      w_state_nxt = S_HALT;
        else                w_state_nxt = S_RUN;
      end
      S_HALT: begin
        if (!halt) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (redirect_valid) r_pc <= redirect_pc;
      else if (w_issue)   r_pc <= r_pc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_inflight_pc <= r_pc;
  end

  assign mem_rd_en = w_issue;
  assign mem_addr  = r_pc;
  assign fetch_pc  = r_pc;

  tron_fetch_fifo #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_instr (mem_rdata),
    .i_pc    (r_inflight_pc),
    .i_pop   (w_pop),
    .o_instr (instr),
    .o_pc    (instr_pc),
    .o_valid (instr_valid),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_tron_fetch_unit.sv
// Bench for tron_fetch_unit: directed timing steps plus a randomized phase
// checked by a stream-level model of program order and handshake rules.
module tb_tron_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] fetch_pc;

  int checks = 0;
  int errors = 0;

  logic [15:0] prog [4] = '{16'h5193, 16'h0152, 16'h9101, 16'hF101};

  always #5 clk = ~clk;

  tron_fetch_unit #(
    .ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .fetch_pc(fetch_pc)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] t;
    case (a)
      16'h0000: return 16'h5193;
      16'h0001: return 16'h0152;
      16'h0002: return 16'h9101;
      16'h0003: return 16'hF101;
      default: begin
        t = a ^ 16'h5A5A;
        return {t[7:0], t[15:8]} + a;
      end
    endcase
  endfunction

  // Synchronous program memory; unrequested cycles return a poison word.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem_word(mem_addr) : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream model: next head pc, next issue address, outstanding words.
  logic [15:0] m_head, m_issue, m_p_instr, m_p_pc;
  int          m_out = 0;
  int          m_accepts = 0;
  bit          m_p_valid, m_p_ready, m_p_redir;
  bit          m_p_rst = 1'b1;

  task automatic monitor();
    bit acc;
    if (!reset) begin
      m_head = 16'h0000; m_issue = 16'h0000; m_out = 0;
      m_p_rst = 1'b1; m_p_valid = 1'b0; m_p_redir = 1'b0;
      return;
    end
    if (m_p_redir) chk("valid_after_redirect", instr_valid, 0);
    if (m_p_valid && !m_p_ready && !m_p_redir && !m_p_rst) begin
      chk("hold_valid", instr_valid, 1);
      chk("hold_instr", instr, m_p_instr);
      chk("hold_pc", instr_pc, m_p_pc);
    end
    if (instr_valid) begin
      chk("head_pc", instr_pc, m_head);
      chk("head_word", instr, mem_word(instr_pc));
    end
    if (halt || redirect_valid) chk("no_issue", mem_rd_en, 0);
    if (mem_rd_en) chk("issue_addr", mem_addr, m_issue);
    acc = instr_valid && instr_ready;
    if (acc) m_accepts++;
    if (redirect_valid) begin
      m_head = redirect_pc; m_issue = redirect_pc; m_out = 0;
    end else begin
      if (acc) m_head = m_head + 16'd1;
      if (mem_rd_en) m_issue = m_issue + 16'd1;
      m_out = m_out + int'(mem_rd_en) - int'(acc);
      chk("occupancy_le_depth", (m_out <= DEPTH), 1);
    end
    m_p_valid = instr_valid; m_p_ready = instr_ready; m_p_redir = redirect_valid;
    m_p_instr = instr; m_p_pc = instr_pc; m_p_rst = 1'b0;
  endtask

  task automatic tick();
    #2;
    monitor();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect_valid = 1'b0; halt = 1'b0; instr_ready = 1'b1;
    tick();
    #1;
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_fetch_pc", fetch_pc, 16'h0000);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] a16;
    bit          found;
    int          acc0;
    int          halt_left;
    reset = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 16'h0000; halt = 1'b0;

    // Streaming from reset at one instruction per cycle.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i < 4) begin
        chk("t1_rd_en", mem_rd_en, 1);
        chk("t1_addr", mem_addr, i);
      end
      chk("t1_valid", instr_valid, (i >= 2));
      if (i >= 2) begin
        chk("t1_instr", instr, prog[i-2]);
        chk("t1_pc", instr_pc, i - 2);
      end
      tick();
    end

    // Core stalls for 5 cycles after the first valid.
    do_reset(); tick(); tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_hold_valid", instr_valid, 1);
      chk("t2_hold_instr", instr, prog[0]);
      chk("t2_hold_pc", instr_pc, 0);
      chk("t2_no_issue", mem_rd_en, 0);
      tick();
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_valid", instr_valid, 1);
      chk("t2_order", instr, prog[i]);
      chk("t2_pc", instr_pc, i);
      tick();
    end

    // Redirect with one entry buffered and one read in flight.
    do_reset(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0020;
    #1; chk("t3_redir_no_issue", mem_rd_en, 0); tick();
    redirect_valid = 1'b0;
    #1;
    chk("t3_valid_n1", instr_valid, 0);
    chk("t3_rd_en_n1", mem_rd_en, 1);
    chk("t3_addr_n1", mem_addr, 16'h0020);
    tick();
    #1; chk("t3_valid_n2", instr_valid, 0); tick();
    #1;
    chk("t3_valid_n3", instr_valid, 1);
    chk("t3_pc_n3", instr_pc, 16'h0020);
    chk("t3_instr_n3", instr, mem_word(16'h0020));
    tick();

    // Redirect near the top of the address space wraps to zero.
    do_reset(); tick();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE; tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i < 4) begin
        a16 = 16'hFFFE + 16'(i);
        chk("t4_rd_en", mem_rd_en, 1);
        chk("t4_addr", mem_addr, a16);
      end
      if (i >= 2) begin
        a16 = 16'hFFFE + 16'(i - 2);
        chk("t4_valid", instr_valid, 1);
        chk("t4_pc", instr_pc, a16);
        chk("t4_instr", instr, mem_word(a16));
      end
      tick();
    end

    // Halt for 4 cycles with a read in flight.
    do_reset(); tick(); tick(); tick();
    halt = 1'b1;
    #1; chk("t5_rd_en_h0", mem_rd_en, 0); tick();
    #1;
    chk("t5_inflight_valid", instr_valid, 1);
    chk("t5_inflight_pc", instr_pc, 2);
    chk("t5_inflight_instr", instr, prog[2]);
    chk("t5_rd_en_h1", mem_rd_en, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t5_drained", instr_valid, 0);
      chk("t5_rd_en_h", mem_rd_en, 0);
      chk("t5_fetch_pc", fetch_pc, 3);
      tick();
    end
    halt = 1'b0; found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found) begin
        #1;
        if (mem_rd_en) begin
          found = 1'b1;
          chk("t5_resume_addr", mem_addr, 3);
        end
        tick();
      end
    end
    chk("t5_resume_seen", found, 1);

    // Reset mid-stream with a read in flight.
    do_reset(); tick(); tick();
    reset = 1'b0; tick();
    #1;
    chk("t6_rd_en", mem_rd_en, 0);
    chk("t6_valid", instr_valid, 0);
    chk("t6_instr", instr, 0);
    chk("t6_instr_pc", instr_pc, 0);
    chk("t6_fetch_pc", fetch_pc, 16'h0000);
    tick();
    reset = 1'b1;
    #1;
    chk("t6_restart_rd_en", mem_rd_en, 1);
    chk("t6_restart_addr", mem_addr, 16'h0000);
    chk("t6_valid_r0", instr_valid, 0);
    tick();
    #1; chk("t6_valid_r1", instr_valid, 0); tick();
    #1;
    chk("t6_valid_r2", instr_valid, 1);
    chk("t6_pc_r2", instr_pc, 16'h0000);
    chk("t6_instr_r2", instr, prog[0]);
    tick();

    // Randomized ready/redirect/halt traffic against the stream model.
    acc0 = m_accepts; halt_left = 0;
    for (int n = 0; n < 1500; n++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) redirect_pc = 16'hFFFC + 16'($urandom_range(0, 3));
      else redirect_pc = 16'($urandom);
      if (halt_left > 0) begin
        halt = 1'b1; halt_left--;
      end else begin
        halt = 1'b0;
        if ($urandom_range(0, 24) == 0) halt_left = $urandom_range(1, 5);
      end
      tick();
    end
    chk("random_progress", ((m_accepts - acc0) > 300), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
